// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life evolution engine.
// A board is flattened row-major, CELL_W bits per cell: bit0 = alive, bit1 = changed.
package life_pkg;

    localparam int CELL_W      = 2;
    localparam int ALIVE_BIT   = 0;
    localparam int CHANGED_BIT = 1;

    typedef struct packed {
        logic changed;
        logic alive;
    } cell_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ROW,
        DONE
    } evo_state_t;

    function automatic int cell_idx(input int i, input int j, input int n);
        return (i * n + j) * CELL_W;
    endfunction

endpackage

// File: rtl/life_row_compute.sv
// Combinational next-state for one board row from the alive bits of rows r-1, r, r+1.
// Rows outside a dead-boundary board arrive as zero; column wrap is resolved here.
module life_row_compute
    import life_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [N-1:0]             row_up,
    input  logic [N-1:0]             row_mid,
    input  logic [N-1:0]             row_dn,
    input  logic                     wrap,
    output cell_t [N-1:0]            row_next,
    output logic [$clog2(N+1)-1:0]   pop
);

    localparam int POP_W = $clog2(N + 1);

    always_comb begin
        logic [3:0] nbr;
        int         jj;
        logic       in_range;
        logic       alive_new;

        row_next  = '0;
        pop       = '0;
        nbr       = '0;
        jj        = 0;
        in_range  = 1'b0;
        alive_new = 1'b0;
        for (int j = 0; j < N; j++) begin
            nbr = '0;
            for (int dj = -1; dj <= 1; dj++) begin
                jj       = j + dj;
                in_range = 1'b1;
                if (jj < 0) begin
                    jj       = N - 1;
                    in_range = wrap;
                end else if (jj >= N) begin
                    jj       = 0;
                    in_range = wrap;
                end
                // The cell itself sits in row_mid at dj == 0 and is not its own neighbour.
                if (in_range) begin
                    nbr = nbr + {3'b000, row_up[jj]} + {3'b000, row_dn[jj]};
                    if (dj != 0) nbr = nbr + {3'b000, row_mid[jj]};
                end
            end
            alive_new            = (nbr == 4'd3) || (row_mid[j] && (nbr == 4'd2));
            row_next[j].alive    = alive_new;
            row_next[j].changed  = alive_new ^ row_mid[j];
            pop                  = pop + POP_W'(alive_new);
        end
    end

endmodule

// File: rtl/life_evolution_engine.sv
// Row-serial Conway generation engine: snapshot the board on start, then produce one
// row of the new board per cycle, reporting live count and generation number on finish.
module life_evolution_engine
    import life_pkg::*;
#(
    parameter int P_PARAM_N = 5,
    parameter int P_GEN_W   = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic                                          wrap_mode,
    input  logic [P_PARAM_N*P_PARAM_N*CELL_W-1:0]         prev,
    output logic [P_PARAM_N*P_PARAM_N*CELL_W-1:0]         next,
    output logic                                          busy,
    output logic                                          finish_evo,
    output logic [$clog2(P_PARAM_N*P_PARAM_N+1)-1:0]      live_count,
    output logic [P_GEN_W-1:0]                            generation
);

    localparam int N     = P_PARAM_N;
    localparam int NC    = N * N;
    localparam int BW    = NC * CELL_W;
    localparam int ROW_W = $clog2(N);
    localparam int POP_W = $clog2(N + 1);
    localparam int CNT_W = $clog2(NC + 1);

    if (P_PARAM_N < 3) begin : g_bad_n
        $error("life_evolution_engine: P_PARAM_N must be at least 3");
    end

    evo_state_t          state_q, state_d;
    logic [ROW_W-1:0]    row_q;
    logic [CNT_W-1:0]    acc_q;
    logic [NC-1:0]       snap_q;
    logic                wrap_q;
    logic [BW-1:0]       next_q;
    logic [CNT_W-1:0]    live_q;
    logic [P_GEN_W-1:0]  gen_q;

    logic [NC-1:0]       prev_alive;
    logic                unused_prev_changed;
    logic [N-1:0]        row_up, row_mid, row_dn;
    cell_t [N-1:0]       new_row;
    logic [POP_W-1:0]    row_pop;
    logic                last_row;

    // Incoming changed flags carry no information for the next generation.
    always_comb begin
        prev_alive          = '0;
        unused_prev_changed = 1'b0;
        for (int k = 0; k < NC; k++) begin
            prev_alive[k]       = prev[k*CELL_W + ALIVE_BIT];
            unused_prev_changed = unused_prev_changed ^ prev[k*CELL_W + CHANGED_BIT];
        end
    end

    assign last_row = (row_q == ROW_W'(N - 1));

    always_comb begin
        row_mid = snap_q[int'(row_q)*N +: N];
        row_up  = '0;
        row_dn  = '0;
        if (row_q != '0)  row_up = snap_q[(int'(row_q) - 1)*N +: N];
        else if (wrap_q)  row_up = snap_q[(N - 1)*N +: N];
        if (!last_row)    row_dn = snap_q[(int'(row_q) + 1)*N +: N];
        else if (wrap_q)  row_dn = snap_q[0 +: N];
    end

    life_row_compute #(.N(N)) u_row (
        .row_up   (row_up),
        .row_mid  (row_mid),
        .row_dn   (row_dn),
        .wrap     (wrap_q),
        .row_next (new_row),
        .pop      (row_pop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = ROW;
            ROW:     if (last_row) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Results for the final row, live count and generation all land on the edge into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q  <= '0;
            acc_q  <= '0;
            snap_q <= '0;
            wrap_q <= 1'b0;
            next_q <= '0;
            live_q <= '0;
            gen_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        snap_q <= prev_alive;
                        wrap_q <= wrap_mode;
                    end
                end
                LOAD: begin
                    row_q <= '0;
                    acc_q <= '0;
                end
                ROW: begin
                    next_q[cell_idx(int'(row_q), 0, N) +: N*CELL_W] <= new_row;
                    acc_q <= acc_q + CNT_W'(row_pop);
                    row_q <= row_q + ROW_W'(1);
                    if (last_row) begin
                        live_q <= acc_q + CNT_W'(row_pop);
                        gen_q  <= gen_q + P_GEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign next       = next_q;
    assign busy       = (state_q == LOAD) || (state_q == ROW);
    assign finish_evo = (state_q == DONE);
    assign live_count = live_q;
    assign generation = gen_q;

endmodule

// File: tb/tb_life_evolution_engine.sv
// Self-checking bench for life_evolution_engine (N=5): table-driven boards, random boards
// against a reference model, handshake, snapshot isolation and mid-generation reset.
module tb_life_evolution_engine;

    localparam int N  = 5;
    localparam int NB = N * N * 2;
    localparam int CW = $clog2(N * N + 1);
    localparam int GW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          wrap_mode;
    logic [NB-1:0] prev;
    logic [NB-1:0] next;
    logic          busy;
    logic          finish_evo;
    logic [CW-1:0] live_count;
    logic [GW-1:0] generation;

    int checks   = 0;
    int failures = 0;
    int gen_exp  = 0;

    typedef struct {
        logic [NB-1:0] nxt;
        int            live;
        int            gen;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        string         name;
        logic [NB-1:0] prev;
        bit            wrap;
        logic [NB-1:0] exp_next;
        int            exp_live;
    } vec_t;
    vec_t tv[7];

    life_evolution_engine #(.P_PARAM_N(N), .P_GEN_W(GW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .wrap_mode  (wrap_mode),
        .prev       (prev),
        .next       (next),
        .busy       (busy),
        .finish_evo (finish_evo),
        .live_count (live_count),
        .generation (generation)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] c(input int i, input int j, input logic [1:0] v);
        logic [NB-1:0] b;
        b = '0;
        b[(i*N + j)*2 +: 2] = v;
        return b;
    endfunction

    function automatic logic [NB-1:0] life_ref(input logic [NB-1:0] p, input bit w, output int live);
        logic [NB-1:0] r;
        int cnt, ii, jj;
        bit a, na, inb;
        r = '0;
        live = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                cnt = 0;
                for (int di = -1; di <= 1; di++) begin
                    for (int dj = -1; dj <= 1; dj++) begin
                        if (di != 0 || dj != 0) begin
                            ii = i + di;
                            jj = j + dj;
                            if (w) begin
                                ii = (ii + N) % N;
                                jj = (jj + N) % N;
                                inb = 1'b1;
                            end else begin
                                inb = (ii >= 0) && (ii < N) && (jj >= 0) && (jj < N);
                            end
                            if (inb && p[(ii*N + jj)*2]) cnt++;
                        end
                    end
                end
                a  = p[(i*N + j)*2];
                na = (cnt == 3) || (a && cnt == 2);
                r[(i*N + j)*2]     = na;
                r[(i*N + j)*2 + 1] = na ^ a;
                if (na) live++;
            end
        end
        return r;
    endfunction

    // Scoreboard consumer: every finish_evo pulse must match the oldest pending expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && finish_evo === 1'b1) begin
            chk("pending_expect", 64'(sbq.size() != 0), 64'(1));
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("next", 64'(next), 64'(e.nxt));
                chk("live_count", 64'(live_count), 64'(e.live));
                chk("generation", 64'(generation), 64'(e.gen));
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic do_gen(input string tag, input logic [NB-1:0] p, input bit w,
                          input logic [NB-1:0] en, input int el, input bit scramble);
        int cyc;
        prev      = p;
        wrap_mode = w;
        start     = 1'b1;
        gen_exp++;
        sbq.push_back(exp_t'{en, el, gen_exp});
        @(negedge clk);
        start = 1'b0;
        cyc   = 2;
        chk({tag, "_busy_load"}, 64'(busy), 64'(1));
        if (scramble) prev = '1;
        while (finish_evo !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(N + 3));
        chk({tag, "_busy_done"}, 64'(busy), 64'(0));
        if (finish_evo !== 1'b1 && sbq.size() != 0) void'(sbq.pop_front());
        @(negedge clk);
        chk({tag, "_pulse_width"}, 64'(finish_evo), 64'(0));
    endtask

    task automatic handshake(input int accepts, input logic [NB-1:0] p, input logic [NB-1:0] en);
        int highs;
        highs     = 0;
        prev      = p;
        wrap_mode = 1'b0;
        for (int a = 0; a < accepts; a++) begin
            gen_exp++;
            sbq.push_back(exp_t'{en, 3, gen_exp});
        end
        start = 1'b1;
        repeat (accepts * (N + 3)) begin
            @(negedge clk);
            if (finish_evo === 1'b1) highs++;
        end
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (finish_evo === 1'b1) highs++;
        end
        chk("handshake_pulses", 64'(highs), 64'(accepts));
        chk("handshake_drained", 64'(sbq.size()), 64'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [NB-1:0] blink_p, blink_e, edge_p, block_p, odd, rp, re;
        int            rl, hi;

        rst       = 1'b1;
        start     = 1'b0;
        wrap_mode = 1'b0;
        prev      = '0;

        odd = '0;
        for (int k = 0; k < N*N; k++) odd[k*2 + 1] = 1'b1;
        blink_p = c(2,1,2'b01) | c(2,2,2'b01) | c(2,3,2'b01);
        blink_e = c(1,2,2'b11) | c(2,2,2'b01) | c(3,2,2'b11) | c(2,1,2'b10) | c(2,3,2'b10);
        edge_p  = c(4,1,2'b01) | c(0,1,2'b01) | c(1,1,2'b01);
        block_p = c(1,1,2'b01) | c(1,2,2'b01) | c(2,1,2'b01) | c(2,2,2'b01);

        tv[0] = '{"blinker", blink_p, 1'b0, blink_e, 3};
        tv[1] = '{"edge_wrap", edge_p, 1'b1,
                  c(0,0,2'b11) | c(0,1,2'b01) | c(0,2,2'b11) | c(4,1,2'b10) | c(1,1,2'b10), 3};
        tv[2] = '{"edge_dead", edge_p, 1'b0, c(4,1,2'b10) | c(0,1,2'b10) | c(1,1,2'b10), 0};
        tv[3] = '{"block_dead", block_p, 1'b0, block_p, 4};
        tv[4] = '{"block_wrap", block_p, 1'b1, block_p, 4};
        tv[5] = '{"empty", '0, 1'b1, '0, 0};
        tv[6] = '{"blinker_bit1", blink_p | odd, 1'b0, blink_e, 3};

        repeat (2) @(negedge clk);
        chk("rst_next", 64'(next), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_finish", 64'(finish_evo), 64'(0));
        chk("rst_live", 64'(live_count), 64'(0));
        chk("rst_gen", 64'(generation), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'(0));

        for (int k = 0; k < 7; k++)
            do_gen(tv[k].name, tv[k].prev, tv[k].wrap, tv[k].exp_next, tv[k].exp_live, 1'b0);

        for (int k = 0; k < 4; k++) begin
            rp = '0;
            for (int m = 0; m < NB; m++) rp[m] = 1'($urandom_range(0, 1));
            hi = k % 2;
            re = life_ref(rp, hi[0], rl);
            do_gen("random", rp, hi[0], re, rl, 1'b0);
        end

        do_gen("snapshot", blink_p, 1'b0, blink_e, 3, 1'b1);

        handshake(1, blink_p, blink_e);
        handshake(2, blink_p, blink_e);

        // Reset while ROW is processing row 2.
        prev      = blink_p;
        wrap_mode = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_busy_before", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        chk("midrst_next", 64'(next), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_finish", 64'(finish_evo), 64'(0));
        chk("midrst_live", 64'(live_count), 64'(0));
        chk("midrst_gen", 64'(generation), 64'(0));
        gen_exp = 0;
        hi      = 0;
        repeat (N + 3) begin
            @(negedge clk);
            if (finish_evo === 1'b1) hi++;
        end
        chk("midrst_no_pulse", 64'(hi), 64'(0));

        // Release reset with start already high, then run the still life three times.
        rst = 1'b0;
        for (int g = 0; g < 3; g++) do_gen("still_life", block_p, 1'b0, block_p, 4, 1'b0);
        chk("still_gen3", 64'(generation), 64'(3));
        chk("still_live", 64'(live_count), 64'(4));

        do_gen("after_reset_blinker", blink_p, 1'b0, blink_e, 3, 1'b0);
        chk("sb_empty", 64'(sbq.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/life_evolution_engine.md
Name: life_evolution_engine

Overview:
Parametrised, row-serial Game of Life generation engine for the logic layer. It sits between the board-state register and the display/update controller. It computes one full Conway generation per start request, using the 2-bit-per-cell flat board encoding, and supports toroidal or dead-boundary edges. It reports completion, live-cell count and generation number through a start/finish handshake.

Parameters:
P_PARAM_N, 5, board side length in cells; must be >= 3, elaborate-time assertion.
P_GEN_W, 16, width of the generation counter.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request one generation; honoured only in IDLE
wrap_mode  input  1  1 = toroidal edges, 0 = cells outside the board are dead; sampled with start
prev  input  P_PARAM_N*P_PARAM_N*2  current board
next  output  P_PARAM_N*P_PARAM_N*2  computed board
busy  output  1  high from LOAD through ROW
finish_evo  output  1  one-cycle pulse when next is complete
live_count  output  $clog2(P_PARAM_N*P_PARAM_N+1)  live cells in next
generation  output  P_GEN_W  count of completed generations

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port rst.
- Cell (i,j) occupies bits [(i*N+j)*2 +: 2], where i is the row and j is the column.
  - Bit0 = alive.
  - Bit1 = changed flag: set when the new bit0 differs from the snapshot bit0.
  - Input bit1 is ignored for the computation.
- Reset values:
  - next = 0, busy = 0, finish_evo = 0, live_count = 0, generation = 0.
  - FSM = IDLE; snapshot and the sampled wrap_mode are cleared.
- FSM states: IDLE, LOAD, ROW, DONE.
- IDLE:
  - start=1 → LOAD.
  - At that edge, latch prev into an internal snapshot and latch wrap_mode.
- LOAD: clear the row index and the live-count accumulator; → ROW next cycle.
- ROW: one row per cycle.
  - For row r, compute all N cells from snapshot rows r-1, r, r+1 and write row r of next.
  - Add the row's popcount to the accumulator.
  - At r = N-1 → DONE.
- DONE:
  - finish_evo = 1 for exactly this cycle.
  - live_count loads the final accumulator (next and live_count are visible together).
  - generation increments, wrapping modulo 2^P_GEN_W.
  - → IDLE.
- Latency: start sampled at edge t gives finish_evo high during cycle t+N+2, i.e. N+3 cycles per generation, with start held for one cycle only.
- Neighbour count: 0..8, held in 4 bits.
  - wrap_mode=1: neighbour indices are taken modulo N.
  - wrap_mode=0: out-of-range neighbours count as dead.
- Rule:
  - A dead cell with exactly 3 live neighbours becomes alive.
  - A live cell with 2 or 3 live neighbours stays alive.
  - All other cells become dead.
- start while busy or in DONE is ignored and not queued.
- prev may change freely after the start edge; only the snapshot is used.
- During ROW, next is partially updated: rows below r hold the new generation, rows at r and above hold the previous result. Consumers read next only at or after finish_evo.
- live_count and generation hold their values between generations.
- rst asserted mid-generation: immediate return to the reset values listed above, with no finish_evo pulse.
- start asserted in the same cycle as rst deassertion: must be accepted on the first clk edge after rst falls.

Decomposition:
- Package life_pkg:
  - cell_t typedef (2-bit packed: changed, alive).
  - evo_state_t enum.
  - Constants CELL_W=2, ALIVE_BIT=0, CHANGED_BIT=1.
  - Function cell_idx(i,j,N).
- Sub-module life_row_compute: combinational next-row computation.
  - Inputs: three N-cell rows, wrap flag.
  - Outputs: N new cells and the row popcount.
- The top module holds the FSM, snapshot, row counter and accumulators.

Test Plan:
- Blinker, N=5, wrap=0: prev alive at (2,1),(2,2),(2,3); start pulse.
  - finish_evo fires exactly N+3=8 cycles after the start edge.
  - next alive at (1,2),(2,2),(3,2); live_count=3.
  - Changed flag set on (1,2),(3,2),(2,1),(2,3) only.
  - generation=1.
- Edge wrap, N=5: prev alive at (4,1),(0,1),(1,1).
  - wrap=1: next alive at (0,0),(0,1),(0,2), live_count=3.
  - Repeat with wrap=0: all cells dead, live_count=0, changed set on those three cells.
- Still life: 2x2 block at (1,1)..(2,2), run 3 generations back-to-back.
  - next is unchanged, all bit1=0, live_count=4, generation=3.
- Handshake: assert start again on every cycle while busy.
  - Only one finish_evo per accepted start.
  - Pulse width exactly 1 cycle; generation increments by 1 per accepted start.
- Snapshot isolation: change prev to all-ones one cycle after start.
  - Result equals the blinker result from the first scenario.
- Reset mid-operation: assert rst during ROW at r=2.
  - All outputs are 0 asynchronously and no finish_evo pulse occurs.
  - A following start produces correct results.
